// File: rtl/cam_pixel_packer.sv
// Camera pixel packer: gathers 8-bit pixel bytes from a sync-framed camera
// bus into big-endian 32-bit words and writes them into a ping-pong pair of
// FIFO write channels, with a one-word holding register for when neither
// channel is available.
module cam_pixel_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic        i_reset_counts,
  input  logic        i_vsync,
  input  logic        i_hsync,
  input  logic [7:0]  i_pix_data,
  input  logic [1:0]  i_wfifo_ready,
  output logic [1:0]  o_wfifo_activate,
  input  logic [23:0] i_wfifo_size,
  output logic        o_wfifo_strobe,
  output logic [31:0] o_wfifo_data,
  output logic [31:0] o_row_count,
  output logic [31:0] o_pixel_count,
  output logic        o_captured,
  output logic        o_busy,
  output logic        o_overflow
);

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, ACTIVE, FLUSH} state_t;

  state_t      state, state_next;
  logic        vsync_d, hsync_d;
  logic [31:0] acc, acc_next;
  logic [1:0]  byte_cnt, cnt_next;
  logic [31:0] pix_in_row;
  logic [23:0] word_count;
  logic        pend_valid;
  logic [31:0] pend_data;
  logic        row_done;

  logic        vsync_rise, frame_start, byte_in, row_end;
  logic        word_done;
  logic [31:0] word_val;
  logic        owned, count_full, write_ok, write_pend, write_new;
  logic        hold_new, drop_new, acquire, release_ch;

  assign vsync_rise  = i_vsync && !vsync_d;
  assign frame_start = (state == WAIT_FRAME) && (state_next == ACTIVE);
  assign byte_in     = (state == ACTIVE) && i_hsync;
  assign row_end     = (state == ACTIVE) && hsync_d && !i_hsync;
  assign o_busy      = (state == ACTIVE) || (state == FLUSH);

  // State register; reset parks the packer in IDLE.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: only start on a clean vsync rise, flush on frame end or disable.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (i_enable && !i_vsync) state_next = WAIT_FRAME;
      WAIT_FRAME: begin
        if (!i_enable)       state_next = IDLE;
        else if (vsync_rise) state_next = ACTIVE;
      end
      ACTIVE:     if (!i_enable || !i_vsync) state_next = FLUSH;
      FLUSH:      state_next = i_enable ? WAIT_FRAME : IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Byte assembly: first byte lands in the top lane; a short row or a flush pads with zeros.
  always_comb begin
    acc_next  = acc;
    cnt_next  = byte_cnt;
    word_done = 1'b0;
    word_val  = 32'd0;
    if (byte_in) begin
      case (byte_cnt)
        2'd0: acc_next[31:24] = i_pix_data;
        2'd1: acc_next[23:16] = i_pix_data;
        2'd2: acc_next[15:8]  = i_pix_data;
        default: begin
          word_done = 1'b1;
          word_val  = {acc[31:8], i_pix_data};
          acc_next  = 32'd0;
        end
      endcase
      cnt_next = byte_cnt + 2'd1;
    end else if (row_end || (state == FLUSH)) begin
      word_done = (byte_cnt != 2'd0);
      word_val  = acc;
      acc_next  = 32'd0;
      cnt_next  = 2'd0;
    end
  end

  // Channel arbitration: decide writes, holding, drops, acquisition and release.
  always_comb begin
    owned      = (o_wfifo_activate != 2'b00);
    count_full = (word_count >= i_wfifo_size);
    write_ok   = owned && !count_full && !(row_done && !pend_valid);
    write_pend = write_ok && pend_valid;
    write_new  = write_ok && !pend_valid && word_done;
    hold_new   = word_done && !write_new && (!pend_valid || write_pend);
    drop_new   = word_done && pend_valid && !write_pend;
    acquire    = !owned && (i_wfifo_ready != 2'b00) &&
                 ((state == WAIT_FRAME) || (state == ACTIVE));
    release_ch = owned && !(write_pend || write_new) &&
                 (count_full || (row_done && !pend_valid) ||
                  (state == FLUSH) || (state == IDLE));
  end

  // Datapath registers: packing, FIFO interface, holding word, counters and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_d          <= 1'b0;
      hsync_d          <= 1'b0;
      acc              <= 32'd0;
      byte_cnt         <= 2'd0;
      pix_in_row       <= 32'd0;
      word_count       <= 24'd0;
      pend_valid       <= 1'b0;
      pend_data        <= 32'd0;
      row_done         <= 1'b0;
      o_wfifo_activate <= 2'b00;
      o_wfifo_strobe   <= 1'b0;
      o_wfifo_data     <= 32'd0;
      o_row_count      <= 32'd0;
      o_pixel_count    <= 32'd0;
      o_captured       <= 1'b0;
      o_overflow       <= 1'b0;
    end else begin
      vsync_d <= i_vsync;
      hsync_d <= i_hsync;

      if (frame_start) begin
        acc      <= 32'd0;
        byte_cnt <= 2'd0;
      end else begin
        acc      <= acc_next;
        byte_cnt <= cnt_next;
      end

      o_wfifo_strobe <= write_pend || write_new;
      if (write_pend)     o_wfifo_data <= pend_data;
      else if (write_new) o_wfifo_data <= word_val;

      if (hold_new) begin
        pend_valid <= 1'b1;
        pend_data  <= word_val;
      end else if (write_pend) begin
        pend_valid <= 1'b0;
      end

      if (acquire) begin
        o_wfifo_activate <= i_wfifo_ready[0] ? 2'b01 : 2'b10;
        word_count       <= 24'd0;
      end else begin
        if (release_ch) o_wfifo_activate <= 2'b00;
        if (write_pend || write_new) word_count <= word_count + 24'd1;
      end

      if (row_end || (state == FLUSH))           row_done <= 1'b1;
      else if (release_ch || (!owned && !pend_valid)) row_done <= 1'b0;

      if (i_reset_counts) begin
        o_row_count   <= 32'd0;
        o_pixel_count <= 32'd0;
        pix_in_row    <= 32'd0;
      end else if (frame_start) begin
        o_row_count <= 32'd0;
        pix_in_row  <= 32'd0;
      end else if (row_end) begin
        o_row_count   <= o_row_count + 32'd1;
        o_pixel_count <= pix_in_row;
        pix_in_row    <= 32'd0;
      end else if (byte_in) begin
        pix_in_row <= pix_in_row + 32'd1;
      end

      if (i_reset_counts) o_overflow <= 1'b0;
      else if (drop_new)  o_overflow <= 1'b1;

      o_captured <= (state == FLUSH) && (o_row_count != 32'd0);
    end
  end

endmodule

// File: tb/tb_cam_pixel_packer.sv
// Self-checking bench for cam_pixel_packer: a table of single rows inside one
// frame, plus directed sequences for channel swap, overflow, zero capacity,
// disable mid-frame and reset mid-row.
module tb_cam_pixel_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_enable, i_reset_counts, i_vsync, i_hsync;
  logic [7:0]  i_pix_data;
  logic [1:0]  i_wfifo_ready;
  logic [1:0]  o_wfifo_activate;
  logic [23:0] i_wfifo_size;
  logic        o_wfifo_strobe;
  logic [31:0] o_wfifo_data, o_row_count, o_pixel_count;
  logic        o_captured, o_busy, o_overflow;

  int tests = 0;
  int fails = 0;
  int cap_count = 0;
  logic [31:0] strobe_q[$];
  logic [1:0]  act_q[$];

  typedef struct {
    int          nbytes;
    logic [7:0]  first;
    logic [7:0]  step;
    int          nwords;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] pix;
  } row_vec_t;

  row_vec_t vecs[6];

  cam_pixel_packer dut (
    .clk              (clk),
    .rst              (rst),
    .i_enable         (i_enable),
    .i_reset_counts   (i_reset_counts),
    .i_vsync          (i_vsync),
    .i_hsync          (i_hsync),
    .i_pix_data       (i_pix_data),
    .i_wfifo_ready    (i_wfifo_ready),
    .o_wfifo_activate (o_wfifo_activate),
    .i_wfifo_size     (i_wfifo_size),
    .o_wfifo_strobe   (o_wfifo_strobe),
    .o_wfifo_data     (o_wfifo_data),
    .o_row_count      (o_row_count),
    .o_pixel_count    (o_pixel_count),
    .o_captured       (o_captured),
    .o_busy           (o_busy),
    .o_overflow       (o_overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Bus monitor: collect strobed words and ownership, count capture pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_wfifo_strobe) begin
        strobe_q.push_back(o_wfifo_data);
        act_q.push_back(o_wfifo_activate);
        checkOutput("strobe_onehot", 32'($onehot(o_wfifo_activate)), 32'd1);
      end
      if (o_wfifo_activate == 2'b11)
        checkOutput("activate_both", 32'(o_wfifo_activate), 32'd0);
      if (o_captured) cap_count++;
    end
  end

  task automatic applyStimulus(input logic en, input logic vs, input logic hs,
                               input logic [7:0] d);
    i_enable   = en;
    i_vsync    = vs;
    i_hsync    = hs;
    i_pix_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst            = 1'b1;
    i_reset_counts = 1'b0;
    i_wfifo_ready  = 2'b01;
    i_wfifo_size   = 24'd1000;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    strobe_q.delete();
    act_q.delete();
    cap_count = 0;
  endtask

  task automatic startFrame();
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    vecs[0] = '{8, 8'h11, 8'h11, 2, 32'h11223344, 32'h55667788, 32'd8};
    vecs[1] = '{6, 8'hAA, 8'h11, 2, 32'hAABBCCDD, 32'hEEFF0000, 32'd6};
    vecs[2] = '{1, 8'h5A, 8'h00, 1, 32'h5A000000, 32'h0, 32'd1};
    vecs[3] = '{3, 8'h01, 8'h01, 1, 32'h01020300, 32'h0, 32'd3};
    vecs[4] = '{5, 8'h10, 8'h10, 2, 32'h10203040, 32'h50000000, 32'd5};
    vecs[5] = '{4, 8'hC0, 8'h01, 1, 32'hC0C1C2C3, 32'h0, 32'd4};

    doReset();
    checkOutput("rst_activate", 32'(o_wfifo_activate), 32'd0);
    checkOutput("rst_strobe",   32'(o_wfifo_strobe), 32'd0);
    checkOutput("rst_data",     o_wfifo_data, 32'd0);
    checkOutput("rst_rows",     o_row_count, 32'd0);
    checkOutput("rst_pixels",   o_pixel_count, 32'd0);
    checkOutput("rst_busy",     32'(o_busy), 32'd0);
    checkOutput("rst_overflow", 32'(o_overflow), 32'd0);

    // Table of rows within a single frame on channel 0.
    startFrame();
    for (int r = 0; r < 6; r++) begin
      strobe_q.delete();
      act_q.delete();
      for (int i = 0; i < vecs[r].nbytes; i++)
        applyStimulus(1'b1, 1'b1, 1'b1, vecs[r].first + 8'(i) * vecs[r].step);
      idleCycles(6);
      checkOutput($sformatf("row%0d_nwords", r), 32'(strobe_q.size()), 32'(vecs[r].nwords));
      if (strobe_q.size() > 0) begin
        checkOutput($sformatf("row%0d_w0", r), strobe_q[0], vecs[r].w0);
        checkOutput($sformatf("row%0d_ch0", r), 32'(act_q[0]), 32'd1);
      end
      if (vecs[r].nwords > 1 && strobe_q.size() > 1)
        checkOutput($sformatf("row%0d_w1", r), strobe_q[1], vecs[r].w1);
      checkOutput($sformatf("row%0d_pix", r), o_pixel_count, vecs[r].pix);
      checkOutput($sformatf("row%0d_rows", r), o_row_count, 32'(r + 1));
      checkOutput($sformatf("row%0d_busy", r), 32'(o_busy), 32'd1);
    end
    cap_count = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("frame_captured", 32'(cap_count), 32'd1);
    checkOutput("frame_rows", o_row_count, 32'd6);
    checkOutput("frame_idle_busy", 32'(o_busy), 32'd0);
    cap_count = 0;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("empty_frame_captured", 32'(cap_count), 32'd0);
    checkOutput("empty_frame_rows", o_row_count, 32'd0);

    // Channel swap: capacity 2, channel 0 stops being ready after it fills.
    doReset();
    i_wfifo_size  = 24'd2;
    i_wfifo_ready = 2'b11;
    startFrame();
    for (int i = 0; i < 12; i++) begin
      if (i == 8) i_wfifo_ready = 2'b10;
      applyStimulus(1'b1, 1'b1, 1'b1, 8'(i + 1));
    end
    idleCycles(6);
    checkOutput("swap_nwords", 32'(strobe_q.size()), 32'd3);
    if (strobe_q.size() == 3) begin
      checkOutput("swap_w0", strobe_q[0], 32'h01020304);
      checkOutput("swap_w1", strobe_q[1], 32'h05060708);
      checkOutput("swap_w2", strobe_q[2], 32'h090A0B0C);
      checkOutput("swap_a0", 32'(act_q[0]), 32'd1);
      checkOutput("swap_a1", 32'(act_q[1]), 32'd1);
      checkOutput("swap_a2", 32'(act_q[2]), 32'd2);
    end

    // No channel ready: first word held, later words dropped.
    doReset();
    i_wfifo_ready = 2'b00;
    startFrame();
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, 1'b1, 8'h21 + 8'(i));
    idleCycles(3);
    checkOutput("ovf_no_strobe", 32'(strobe_q.size()), 32'd0);
    checkOutput("ovf_flag", 32'(o_overflow), 32'd1);
    i_wfifo_ready = 2'b01;
    idleCycles(5);
    checkOutput("ovf_drain_n", 32'(strobe_q.size()), 32'd1);
    if (strobe_q.size() > 0) begin
      checkOutput("ovf_drain_w", strobe_q[0], 32'h21222324);
      checkOutput("ovf_drain_ch", 32'(act_q[0]), 32'd1);
    end
    checkOutput("ovf_sticky", 32'(o_overflow), 32'd1);
    checkOutput("ovf_rows", o_row_count, 32'd1);
    checkOutput("ovf_pix", o_pixel_count, 32'd12);
    i_reset_counts = 1'b1;
    idleCycles(1);
    i_reset_counts = 1'b0;
    checkOutput("clr_overflow", 32'(o_overflow), 32'd0);
    checkOutput("clr_rows", o_row_count, 32'd0);
    checkOutput("clr_pix", o_pixel_count, 32'd0);

    // Zero capacity: channel churns but nothing is ever strobed.
    doReset();
    i_wfifo_size = 24'd0;
    startFrame();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b1, 8'h40 + 8'(i));
    idleCycles(8);
    checkOutput("size0_no_strobe", 32'(strobe_q.size()), 32'd0);

    // Disable mid-row: partial word flushed, no capture pulse, back to idle.
    doReset();
    startFrame();
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h77);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h88);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h99);
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("dis_nwords", 32'(strobe_q.size()), 32'd1);
    if (strobe_q.size() > 0) checkOutput("dis_w0", strobe_q[0], 32'h77889900);
    checkOutput("dis_captured", 32'(cap_count), 32'd0);
    checkOutput("dis_rows", o_row_count, 32'd0);
    checkOutput("dis_busy", 32'(o_busy), 32'd0);
    checkOutput("dis_activate", 32'(o_wfifo_activate), 32'd0);

    // Reset two bytes into a row: nothing written, waits for the next frame.
    doReset();
    startFrame();
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h55);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h66);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h00);
    checkOutput("mrst_activate", 32'(o_wfifo_activate), 32'd0);
    checkOutput("mrst_strobe", 32'(o_wfifo_strobe), 32'd0);
    checkOutput("mrst_busy", 32'(o_busy), 32'd0);
    rst = 1'b0;
    idleCycles(6);
    checkOutput("mrst_no_strobe", 32'(strobe_q.size()), 32'd0);
    checkOutput("mrst_still_idle", 32'(o_wfifo_activate), 32'd0);
    checkOutput("mrst_not_busy", 32'(o_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
